// File: rtl/rr_arbiter_8_pkg.sv
// rtl/rr_arbiter_8_pkg.sv - shared constants and types for the 8-way round-robin arbiter
package rr_arbiter_8_pkg;

   localparam int N_REQ = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Expand a requester index into its one-hot grant vector.
   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// rtl/rr_arbiter_8_pick.sv - rotating first-set-bit search starting just after the pointer
module rr_pick_8
   import rr_arbiter_8_pkg::*;
(
   input  logic [N_REQ-1:0] cand_i,
   input  logic [2:0]       ptr_i,
   output logic [2:0]       win_o,
   output logic             found_o
);

   logic [2:0]       start;
   logic [N_REQ-1:0] rot;
   logic [2:0]       off;

   // Search begins one past the last owner; 3-bit arithmetic gives the 7->0 wrap.
   assign start = ptr_i + 3'd1;

   // Rotate so that bit 0 of rot is the first candidate to be checked.
   always_comb begin
      rot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         rot[k] = cand_i[start + 3'(k)];
      end
   end

   // Fixed-priority encode: lowest set bit of the rotated vector wins.
   always_comb begin
      off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = 3'(k);
         end
      end
   end

   assign win_o   = start + off;
   assign found_o = |cand_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-requester round-robin arbiter with hold timeout and done pulse
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [N_REQ-1:0] Req,
   output logic [N_REQ-1:0] Grant,
   output logic [2:0]       Y,
   output logic             Valid,
   output logic             Done
);

   localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [2:0]       y_q, y_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N_REQ-1:0] others;
   logic [N_REQ-1:0] cand;
   logic [2:0]       win;
   logic             found;
   logic             rel;
   logic             preempt;

   // Candidates: in IDLE the full request vector, while granted everyone but the owner.
   always_comb begin
      others  = Req & ~idx_to_onehot(y_q);
      cand    = (state_q == ST_IDLE) ? Req : others;
      rel     = ~Req[y_q];
      preempt = TIMEOUT_EN && (cnt_q == HOLD_LAST) && (|others);
   end

   rr_pick_8 u_pick (
      .cand_i  (cand),
      .ptr_i   (ptr_q),
      .win_o   (win),
      .found_o (found)
   );

   // Next-state and output decode: grant, hold, handoff, release or revoke.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      y_d     = y_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (EN && found) begin
               state_d = ST_GRANT;
               grant_d = idx_to_onehot(win);
               y_d     = win;
               valid_d = 1'b1;
               ptr_d   = win;
               cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            if (!EN) begin
               // Revoke wins over release: no handoff, single done pulse.
               state_d = ST_IDLE;
               grant_d = '0;
               valid_d = 1'b0;
               done_d  = 1'b1;
            end else if (rel || preempt) begin
               done_d = 1'b1;
               if (found) begin
                  grant_d = idx_to_onehot(win);
                  y_d     = win;
                  ptr_d   = win;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  valid_d = 1'b0;
               end
            end else if (TIMEOUT_EN && (cnt_q != HOLD_LAST)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything without a done pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ptr_q   <= 3'd7;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Grant = grant_q;
   assign Y     = y_q;
   assign Valid = valid_q;
   assign Done  = done_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - scoreboard bench for rr_arbiter_8 against a behavioural model
module tb_rr_arbiter_8;

   localparam int MAX_HOLD = 4;

   logic       CLK = 1'b0;
   logic       RST;
   logic       EN;
   logic [7:0] Req;
   logic [7:0] Grant;
   logic [2:0] Y;
   logic       Valid;
   logic       Done;

   always #5 CLK = ~CLK;

   rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (EN),
      .Req   (Req),
      .Grant (Grant),
      .Y     (Y),
      .Valid (Valid),
      .Done  (Done)
   );

   typedef struct {
      logic [7:0] grant;
      int         y;
      logic       valid;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   int   m_owner = -1;
   int   m_last  = 7;
   int   m_held  = 0;

   function automatic int search(input logic [7:0] v, input int last);
      for (int k = 1; k <= 8; k++) begin
         if (v[(last + k) % 8]) return (last + k) % 8;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic [7:0] rq);
      exp_t       x;
      logic [7:0] oth;
      bit         rel;
      bit         tmo;
      @(negedge CLK);
      RST = r;
      EN  = e;
      Req = rq;
      x.done = 1'b0;
      if (r) begin
         m_owner = -1;
         m_last  = 7;
         m_held  = 0;
      end else if (m_owner < 0) begin
         if (e && rq != 8'h00) begin
            m_owner = search(rq, m_last);
            m_last  = m_owner;
            m_held  = 1;
         end
      end else if (!e) begin
         m_owner = -1;
         x.done  = 1'b1;
      end else begin
         oth          = rq;
         oth[m_owner] = 1'b0;
         rel = !rq[m_owner];
         tmo = (MAX_HOLD != 0) && (m_held >= MAX_HOLD) && (oth != 8'h00);
         if (rel || tmo) begin
            x.done = 1'b1;
            if (oth != 8'h00) begin
               m_owner = search(oth, m_last);
               m_last  = m_owner;
               m_held  = 1;
            end else begin
               m_owner = -1;
            end
         end else begin
            m_held++;
         end
      end
      x.valid = (m_owner >= 0);
      x.grant = 8'h00;
      if (x.valid) x.grant[m_owner] = 1'b1;
      x.y = m_owner;
      exp_q.push_back(x);
   endtask

   exp_t mx;
   always @(posedge CLK) begin
      #1;
      if (exp_q.size() > 0) begin
         mx = exp_q.pop_front();
         chk("valid", 32'(Valid), 32'(mx.valid));
         chk("grant", 32'(Grant), 32'(mx.grant));
         chk("done", 32'(Done), 32'(mx.done));
         if (mx.valid) chk("y", 32'(Y), 32'(mx.y));
         chk("valid_eq_or_grant", 32'(Valid), 32'(|Grant));
         chk("grant_onehot0", 32'($countones(Grant) <= 1), 32'(1));
         if (Valid) chk("grant_at_y", 32'(Grant[Y]), 32'(1));
      end
   end

   logic [7:0] r;
   int         b;
   logic       e;
   logic       rs;

   initial begin
      RST = 1'b1;
      EN  = 1'b0;
      Req = 8'h00;

      cyc(1, 1, 8'hFF);
      cyc(1, 1, 8'hFF);
      cyc(0, 1, 8'hFF);

      repeat (9) begin
         r = 8'hFF;
         r[m_owner] = 1'b0;
         cyc(0, 1, r);
      end
      cyc(0, 1, 8'hFF);

      cyc(1, 1, 8'h00);
      cyc(0, 1, 8'h40);
      cyc(0, 1, 8'h40);
      cyc(0, 1, 8'h05);
      cyc(0, 1, 8'h04);
      cyc(0, 1, 8'h00);

      cyc(1, 1, 8'h00);
      repeat (8) cyc(0, 1, 8'h03);
      repeat (10) cyc(0, 1, 8'h01);
      cyc(0, 1, 8'h00);

      cyc(1, 1, 8'h00);
      repeat (3) cyc(0, 1, 8'h20);
      cyc(0, 0, 8'h20);
      cyc(0, 0, 8'h20);
      cyc(0, 1, 8'h20);
      cyc(0, 1, 8'h20);
      cyc(0, 0, 8'h00);
      cyc(0, 1, 8'h00);

      cyc(1, 1, 8'h00);
      repeat (2) cyc(0, 1, 8'h08);
      cyc(1, 1, 8'h08);
      cyc(0, 1, 8'h88);
      cyc(0, 1, 8'h88);

      r = 8'h00;
      repeat (3000) begin
         if ($urandom_range(0, 2) == 0) begin
            b = $urandom_range(0, 7);
            r[b] = ~r[b];
         end
         e  = ($urandom_range(0, 11) != 0);
         rs = ($urandom_range(0, 249) == 0);
         cyc(rs, e, r);
      end

      @(posedge CLK);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
